// File: rtl/encoder_8to3_if.sv
// ---------------------------------------------------------------------------
// encoder_8to3_if
// Groups the request/response signals of the 8-to-3 priority encoder.
//   i     [7:0] request vector, bit n maps to code n   (master -> slave)
//   en          encode enable, active high              (master -> slave)
//   y     [2:0] registered index of highest set bit     (slave -> master)
//   valid       registered, 1 when y is a real encode   (slave -> master)
//   err         registered multi-hot flag, only present when
//               ENCODER_ONEHOT_ERR_EN is defined        (slave -> master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface encoder_8to3_if;
  logic [7:0] i;
  logic       en;
  logic [2:0] y;
  logic       valid;
`ifdef ENCODER_ONEHOT_ERR_EN
  logic       err;

  modport master (output i, en, input y, valid, err);
  modport slave  (input i, en, output y, valid, err);
`else
  modport master (output i, en, input y, valid);
  modport slave  (input i, en, output y, valid);
`endif
endinterface

// File: rtl/encoder_8to3.sv
// ---------------------------------------------------------------------------
// encoder_8to3
// Registered 8-to-3 priority encoder with enable. One clock of latency from
// i/en to y/valid; there is no combinational path from inputs to outputs.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (y=0, valid=0 while low)
//   bus    encoder_8to3_if.slave: i, en in; y, valid (and err) out
// Optional feature macro: ENCODER_ONEHOT_ERR_EN
//   When defined, bus.err is registered high whenever en=1 and more than one
//   bit of i is set. When undefined, no multi-hot detection logic exists.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module encoder_8to3 (
  input  logic           clk,
  input  logic           rst_n,
  encoder_8to3_if.slave  bus
);

  logic [2:0] w_idx;
  logic       w_any;
  logic       w_hit;
  logic [2:0] r_y;
  logic       r_valid;

  // Ascending scan: the last set bit seen is the highest, so bit 7 wins.
  always_comb begin
    w_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (bus.i[k]) w_idx = k[2:0];
    end
  end

  assign w_any = |bus.i;
  assign w_hit = bus.en & w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      // Index is forced to zero whenever the result is not a real encode.
      r_y     <= w_hit ? w_idx : 3'd0;
      r_valid <= w_hit;
    end
  end

  assign bus.y     = r_y;
  assign bus.valid = r_valid;

`ifdef ENCODER_ONEHOT_ERR_EN
  logic w_multi;
  logic r_err;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(bus.i & (bus.i - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= bus.en & w_multi;
    end
  end

  assign bus.err = r_err;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
`timescale 1ns/1ps

module tb_encoder_8to3;

  typedef struct packed {
    logic       err;
    logic       valid;
    logic [2:0] y;
    logic [7:0] i;
    logic       en;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  encoder_8to3_if bus();

  encoder_8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: highest set bit is floor(log2(i)); multi-hot means
  // more than one bit counted.
  function automatic exp_t model(input logic en, input logic [7:0] i);
    exp_t e;
    int   v;
    v       = i;
    e.i     = i;
    e.en    = en;
    e.valid = en && (v != 0);
    e.y     = e.valid ? 3'($clog2(v + 1) - 1) : 3'd0;
    e.err   = en && ($countones(i) > 1);
    return e;
  endfunction

  function automatic logic dut_err();
`ifdef ENCODER_ONEHOT_ERR_EN
    return bus.err;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one transaction and record its expected response.
  task automatic drive(input logic en, input logic [7:0] i);
    @(negedge clk);
    bus.en = en;
    bus.i  = i;
    sb_q.push_back(model(en, i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never checked, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (bus.y !== 3'd0 || bus.valid !== 1'b0 || dut_err() !== 1'b0) begin
      errors++;
      $display("FAIL %s: y=%0d valid=%b err=%b, required y=0 valid=0 err=0",
               name, bus.y, bus.valid, dut_err());
    end else begin
      $display("ok   %s: y=0 valid=0", name);
    end
  endtask

  // Monitor: every edge out of reset presents one response.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.y !== e.y || bus.valid !== e.valid
`ifdef ENCODER_ONEHOT_ERR_EN
          || bus.err !== e.err
`endif
         ) begin
        errors++;
        $display("FAIL encode en=%b i=%h: y=%0d valid=%b err=%b, required y=%0d valid=%b err=%b",
                 e.en, e.i, bus.y, bus.valid, dut_err(), e.y, e.valid, e.err);
      end else begin
        $display("ok   encode en=%b i=%h: y=%0d valid=%b", e.en, e.i, bus.y, bus.valid);
      end
    end
  end

  initial begin
    logic [7:0] pri_vec [5];
    logic [7:0] r;
    checks = 0;
    errors = 0;

    // Reset held with an active request: outputs stay cleared.
    rst_n  = 1'b0;
    bus.en = 1'b1;
    bus.i  = 8'h80;
    repeat (3) begin
      @(negedge clk);
      check_reset("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(1'b1, 8'h80));

    // Enable-off sweep.
    for (int k = 0; k < 8; k++) drive(1'b0, 8'(1 << k));
    // Enable-on sweep.
    for (int k = 0; k < 8; k++) drive(1'b1, 8'(1 << k));
    // Interleaved enable.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 8'(1 << k));
      drive(1'b1, 8'(1 << k));
    end
    // Zero and priority.
    pri_vec[0] = 8'h00; pri_vec[1] = 8'hFF; pri_vec[2] = 8'h0A;
    pri_vec[3] = 8'h03; pri_vec[4] = 8'h90;
    for (int k = 0; k < 5; k++) drive(1'b1, pri_vec[k]);

    // Randomized traffic, biased toward enabled and sometimes one-hot.
    for (int k = 0; k < 40; k++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = 8'(1 << $urandom_range(0, 7));
      drive(($urandom_range(0, 4) != 0), r);
    end

    // Async reset between edges while a valid encode is being held.
    drive(1'b1, 8'h20);
    drive(1'b1, 8'h20);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_now");
    @(negedge clk);
    check_reset("async_reset_hold");
    rst_n = 1'b1;
    sb_q.push_back(model(1'b1, 8'h20));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
